// File: rtl/regfile_pkg.sv
// regfile_pkg: defaults and helpers shared by the register file and the
// decode/writeback stages that build its packed port buses.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   port_lsb()              : lsb of port 'port' in a bus of 'width'-bit slots
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 36;
    localparam int unsigned ADDR_W_DEF = 5;

    function automatic int unsigned port_lsb(input int unsigned port,
                                             input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port of the register file.
//   clk, rst_n        : clock, async active-low reset (clears rd_data)
//   rd_en, rd_addr    : read request; rd_data holds when rd_en is low
//   mem               : current contents of the storage array
//   wr_en/addr/data   : write-port buses, used for same-cycle bypass
//   rd_data           : registered read data
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned DEPTH   = 2**ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]      wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]             rd_data
);

    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Later write ports override earlier ones, so the highest-numbered
    // matching port supplies the bypass data, same as the write priority.
    // The zero register is applied last so it beats any bypass.
    always_comb begin
        value = mem[rd_addr];
        if (BYPASS) begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_addr[port_lsb(k, ADDR_W) +: ADDR_W] == rd_addr)) begin
                    value = wr_data[port_lsb(k, DATA_W) +: DATA_W];
                end
            end
        end
        if (ZERO_REG && (rd_addr == '0)) begin
            value = '0;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/multiport_regfile.sv
// multiport_regfile: parametrised register file with NUM_WR write ports
// (highest port wins on collision) and NUM_RD registered read ports.
//   clk, rst_n          : clock, async active-low reset (clears all state)
//   wr_en/addr/data     : packed write ports, port k at [k*W +: W]
//   rd_en/addr          : packed read requests
//   rd_data             : packed registered read data
//   wr_conflict         : registered flag, both write ports hit one address
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     wr_conflict
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_d;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic                         wr_conflict_d;
    logic                         wr_conflict_q;

    // Ports are applied in ascending order so the last (port 1) wins.
    always_comb begin
        logic [ADDR_W-1:0] waddr;
        waddr = '0;
        mem_d = mem_q;
        for (int unsigned k = 0; k < NUM_WR; k++) begin
            waddr = wr_addr[port_lsb(k, ADDR_W) +: ADDR_W];
            if (wr_en[k] && !(ZERO_REG && (waddr == '0))) begin
                mem_d[waddr] = wr_data[port_lsb(k, DATA_W) +: DATA_W];
            end
        end
    end

    generate
        if (NUM_WR > 1) begin : g_conflict
            // Writes to the hardwired zero entry are discarded, so they
            // cannot collide.
            assign wr_conflict_d = wr_en[0] && wr_en[1]
                                 && (wr_addr[0 +: ADDR_W] == wr_addr[ADDR_W +: ADDR_W])
                                 && !(ZERO_REG && (wr_addr[0 +: ADDR_W] == '0));
        end else begin : g_no_conflict
            assign wr_conflict_d = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q         <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

    generate
        for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
            regfile_rd_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .NUM_WR   (NUM_WR),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rd_port (
                .clk     (clk),
                .rst_n   (rst_n),
                .rd_en   (rd_en[j]),
                .rd_addr (rd_addr[j*ADDR_W +: ADDR_W]),
                .mem     (mem_q),
                .wr_en   (wr_en),
                .wr_addr (wr_addr),
                .wr_data (wr_data),
                .rd_data (rd_data[j*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule
